// File: rtl/instr_decode_pipe.sv
// RV32I decode stage: decodes one instruction per cycle, captures operands, and queues
// decoded entries in a small FIFO toward execute with load-use stall and flush support.
package instr_decode_pkg;
    typedef enum logic [5:0] {
        OP_NOP, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
    } op_e;
endpackage

module instr_decode_pipe
    import instr_decode_pkg::*;
#(
    parameter int wd_instr_p  = 32,
    parameter int wd_regs_p   = 32,
    parameter int n_regs_p    = 32,
    parameter int wd_pc_p     = 32,
    parameter int buf_depth_p = 2,
    localparam int wd_addr_p  = $clog2(n_regs_p)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [wd_instr_p-1:0]            i_instr,
    input  logic [wd_pc_p-1:0]               i_pc,
    output logic [1:0][wd_addr_p-1:0]        o_reg_rd_addr,
    input  logic [1:0][wd_regs_p-1:0]        i_reg_rd_data,
    input  logic                             i_load_pend,
    input  logic [wd_addr_p-1:0]             i_load_rdest,
    input  logic                             i_flush,
    output logic                             o_valid,
    input  logic                             i_ready,
    output op_e                              o_op,
    output logic [wd_regs_p-1:0]             o_imm_se,
    output logic [wd_regs_p-1:0]             o_rs1_data,
    output logic [wd_regs_p-1:0]             o_rs2_data,
    output logic [wd_addr_p-1:0]             o_rdest,
    output logic [wd_pc_p-1:0]               o_pc,
    output logic                             o_jump,
    output logic                             o_is_load,
    output logic                             o_wr_en,
    output logic                             o_illegal
);
    localparam int wd_ptr_p = $clog2(buf_depth_p);
    localparam logic [wd_ptr_p:0] depth_c = (wd_ptr_p+1)'(buf_depth_p);

    typedef struct packed {
        op_e                  op;
        logic [wd_regs_p-1:0] imm;
        logic [wd_regs_p-1:0] rs1;
        logic [wd_regs_p-1:0] rs2;
        logic [wd_addr_p-1:0] rdest;
        logic [wd_pc_p-1:0]   pc;
        logic                 jump;
        logic                 is_load;
        logic                 wr_en;
        logic                 illegal;
    } entry_t;

    entry_t                 mem [buf_depth_p];
    entry_t                 dec;
    logic [wd_ptr_p-1:0]    rd_ptr, wr_ptr;
    logic [wd_ptr_p:0]      count;
    logic [buf_depth_p-1:0] ent_vld;
    logic [31:0]            imm32;
    logic                   use1, use2, ill, hazard, acc, deq;
    logic [wd_addr_p-1:0]   rs1, rs2;
    logic [2:0]             f3;
    logic [6:0]             f7;

    assign f3  = i_instr[14:12];
    assign f7  = i_instr[31:25];
    assign rs1 = wd_addr_p'(i_instr[19:15]);
    assign rs2 = wd_addr_p'(i_instr[24:20]);
    assign o_reg_rd_addr = {rs2, rs1};

    always_comb begin
        dec         = '0;
        imm32       = '0;
        use1        = 1'b0;
        use2        = 1'b0;
        ill         = 1'b0;
        dec.pc      = i_pc;
        dec.rs1     = i_reg_rd_data[0];
        dec.rs2     = i_reg_rd_data[1];
        dec.rdest   = wd_addr_p'(i_instr[11:7]);
        case (i_instr[6:0])
            7'b0000011: begin
                dec.is_load = 1'b1; dec.wr_en = 1'b1; use1 = 1'b1;
                imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
                case (f3)
                    3'b000: dec.op = OP_LB;
                    3'b001: dec.op = OP_LH;
                    3'b010: dec.op = OP_LW;
                    3'b100: dec.op = OP_LBU;
                    3'b101: dec.op = OP_LHU;
                    default: ill = 1'b1;
                endcase
            end
            7'b0010011: begin
                dec.wr_en = 1'b1; use1 = 1'b1;
                imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
                case (f3)
                    3'b000: dec.op = OP_ADDI;
                    3'b010: dec.op = OP_SLTI;
                    3'b011: dec.op = OP_SLTIU;
                    3'b100: dec.op = OP_XORI;
                    3'b110: dec.op = OP_ORI;
                    3'b111: dec.op = OP_ANDI;
                    3'b001: if (f7 == 7'b0000000) dec.op = OP_SLLI; else ill = 1'b1;
                    default: begin
                        if (f7 == 7'b0000000)      dec.op = OP_SRLI;
                        else if (f7 == 7'b0100000) dec.op = OP_SRAI;
                        else                       ill = 1'b1;
                    end
                endcase
            end
            7'b0110011: begin
                dec.wr_en = 1'b1; use1 = 1'b1; use2 = 1'b1;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000: dec.op = OP_ADD;
                        3'b001: dec.op = OP_SLL;
                        3'b010: dec.op = OP_SLT;
                        3'b011: dec.op = OP_SLTU;
                        3'b100: dec.op = OP_XOR;
                        3'b101: dec.op = OP_SRL;
                        3'b110: dec.op = OP_OR;
                        default: dec.op = OP_AND;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) dec.op = OP_SUB;
                else if (f7 == 7'b0100000 && f3 == 3'b101)     dec.op = OP_SRA;
                else                                           ill = 1'b1;
            end
            7'b0100011: begin
                use1 = 1'b1; use2 = 1'b1;
                imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
                case (f3)
                    3'b000: dec.op = OP_SB;
                    3'b001: dec.op = OP_SH;
                    3'b010: dec.op = OP_SW;
                    default: ill = 1'b1;
                endcase
            end
            7'b1100011: begin
                dec.jump = 1'b1; use1 = 1'b1; use2 = 1'b1;
                imm32 = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
                case (f3)
                    3'b000: dec.op = OP_BEQ;
                    3'b001: dec.op = OP_BNE;
                    3'b100: dec.op = OP_BLT;
                    3'b101: dec.op = OP_BGE;
                    3'b110: dec.op = OP_BLTU;
                    3'b111: dec.op = OP_BGEU;
                    default: ill = 1'b1;
                endcase
            end
            7'b0110111: begin dec.op = OP_LUI;   dec.wr_en = 1'b1; imm32 = {i_instr[31:12], 12'b0}; end
            7'b0010111: begin dec.op = OP_AUIPC; dec.wr_en = 1'b1; imm32 = {i_instr[31:12], 12'b0}; end
            7'b1100111: begin
                dec.jump = 1'b1; dec.wr_en = 1'b1; use1 = 1'b1;
                imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
                if (f3 == 3'b000) dec.op = OP_JALR; else ill = 1'b1;
            end
            7'b1101111: begin
                dec.op = OP_JAL; dec.jump = 1'b1; dec.wr_en = 1'b1;
                imm32 = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
            end
            default: ill = 1'b1;
        endcase
        // illegal words behave as a harmless bubble: no writes, no operand dependencies
        if (ill) begin
            dec.op = OP_NOP; dec.wr_en = 1'b0; dec.jump = 1'b0; dec.is_load = 1'b0;
            use1 = 1'b0; use2 = 1'b0; imm32 = '0;
        end
        dec.illegal = ill;
        if (dec.rdest == '0) dec.wr_en = 1'b0;
        dec.imm = {wd_regs_p{imm32[31]}};
        dec.imm[31:0] = imm32;
    end

    always_comb begin
        hazard = 1'b0;
        if (i_load_pend && ((use1 && rs1 != '0 && rs1 == i_load_rdest) ||
                            (use2 && rs2 != '0 && rs2 == i_load_rdest)))
            hazard = 1'b1;
        for (int i = 0; i < buf_depth_p; i++)
            if (ent_vld[i] && mem[i].is_load &&
                ((use1 && rs1 != '0 && rs1 == mem[i].rdest) ||
                 (use2 && rs2 != '0 && rs2 == mem[i].rdest)))
                hazard = 1'b1;
    end

    assign o_ready = !rst && !i_flush && !hazard && (count < depth_c);
    assign o_valid = (count != '0);
    assign acc     = i_valid && o_ready;
    assign deq     = o_valid && i_ready;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            ent_vld <= '0;
        end else begin
            if (acc) begin
                wr_ptr          <= wr_ptr + 1'b1;
                ent_vld[wr_ptr] <= 1'b1;
            end
            // rd_ptr == wr_ptr only when empty or full, and neither allows both ops
            if (deq) begin
                rd_ptr          <= rd_ptr + 1'b1;
                ent_vld[rd_ptr] <= 1'b0;
            end
            case ({acc, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < buf_depth_p; i++) mem[i] <= '0;
        end else if (acc) begin
            mem[wr_ptr] <= dec;
        end
    end

    assign o_op       = mem[rd_ptr].op;
    assign o_imm_se   = mem[rd_ptr].imm;
    assign o_rs1_data = mem[rd_ptr].rs1;
    assign o_rs2_data = mem[rd_ptr].rs2;
    assign o_rdest    = mem[rd_ptr].rdest;
    assign o_pc       = mem[rd_ptr].pc;
    assign o_jump     = mem[rd_ptr].jump;
    assign o_is_load  = mem[rd_ptr].is_load;
    assign o_wr_en    = mem[rd_ptr].wr_en;
    assign o_illegal  = mem[rd_ptr].illegal;
endmodule

// File: tb/tb_instr_decode_pipe.sv
// Scoreboard bench for instr_decode_pipe: hand-decoded vectors are queued on accept
// and compared against the FIFO head whenever execute consumes it.
module tb_instr_decode_pipe;
    import instr_decode_pkg::*;

    logic             clk = 1'b0;
    logic             rst, i_valid, i_load_pend, i_flush, i_ready;
    logic             o_ready, o_valid, o_jump, o_is_load, o_wr_en, o_illegal;
    logic [31:0]      i_instr, i_pc, o_imm_se, o_rs1_data, o_rs2_data, o_pc;
    logic [1:0][4:0]  o_reg_rd_addr;
    logic [1:0][31:0] i_reg_rd_data;
    logic [4:0]       i_load_rdest, o_rdest;
    op_e              o_op;

    instr_decode_pipe dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_instr(i_instr),
        .i_pc(i_pc), .o_reg_rd_addr(o_reg_rd_addr), .i_reg_rd_data(i_reg_rd_data),
        .i_load_pend(i_load_pend), .i_load_rdest(i_load_rdest), .i_flush(i_flush),
        .o_valid(o_valid), .i_ready(i_ready), .o_op(o_op), .o_imm_se(o_imm_se),
        .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data), .o_rdest(o_rdest), .o_pc(o_pc),
        .o_jump(o_jump), .o_is_load(o_is_load), .o_wr_en(o_wr_en), .o_illegal(o_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        op_e         op;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        jmp, ld, wr, ill;
    } tv_t;

    typedef struct {
        tv_t         tv;
        logic [31:0] rs1, rs2, pc;
    } sb_t;

    tv_t  tv [14];
    sb_t  sb [$];
    tv_t  cur_tv;
    int   checks = 0, errors = 0;
    logic last_acc, rand_rs;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic tv_t mk(logic [31:0] ins, op_e op, logic [31:0] imm, logic [4:0] rd,
                               logic jmp, logic ld, logic wr, logic ill);
        tv_t t;
        t.instr = ins; t.op = op; t.imm = imm; t.rd = rd;
        t.jmp = jmp; t.ld = ld; t.wr = wr; t.ill = ill;
        return t;
    endfunction

    // one clock: settle, score head/accept, then advance to the next falling edge
    task automatic cyc(input int exp_rdy = -1);
        sb_t e;
        if (rand_rs) begin
            i_reg_rd_data[0] = $urandom;
            i_reg_rd_data[1] = $urandom;
        end
        #1;
        if (exp_rdy >= 0) chk("o_ready", {63'd0, o_ready}, exp_rdy[63:0]);
        last_acc = i_valid && o_ready;
        if (o_valid && i_ready && !i_flush && !rst) begin
            if (sb.size() == 0) chk("sb_unexpected_head", 1, 0);
            else begin
                e = sb.pop_front();
                chk("op",      64'(o_op),      64'(e.tv.op));
                chk("imm",     64'(o_imm_se),  64'(e.tv.imm));
                chk("rs1",     64'(o_rs1_data), 64'(e.rs1));
                chk("rs2",     64'(o_rs2_data), 64'(e.rs2));
                chk("pc",      64'(o_pc),      64'(e.pc));
                chk("jump",    64'(o_jump),    64'(e.tv.jmp));
                chk("is_load", 64'(o_is_load), 64'(e.tv.ld));
                chk("wr_en",   64'(o_wr_en),   64'(e.tv.wr));
                chk("illegal", 64'(o_illegal), 64'(e.tv.ill));
                if (e.tv.wr) chk("rdest", 64'(o_rdest), 64'(e.tv.rd));
            end
        end
        if (last_acc) begin
            e.tv = cur_tv; e.rs1 = i_reg_rd_data[0]; e.rs2 = i_reg_rd_data[1]; e.pc = i_pc;
            sb.push_back(e);
        end
        if (i_flush || rst) sb.delete();
        @(negedge clk);
    endtask

    task automatic push(input int idx, input int exp_rdy = -1);
        int n = 0;
        cur_tv  = tv[idx];
        i_instr = tv[idx].instr;
        i_valid = 1'b1;
        do begin
            cyc(exp_rdy);
            n++;
        end while (!last_acc && n < 20);
        if (!last_acc) chk("accept_timeout", 0, 1);
        i_valid = 1'b0;
        i_pc    = i_pc + 32'd4;
    endtask

    task automatic drain();
        int n = 0;
        i_ready = 1'b1;
        while (sb.size() != 0 && n < 20) begin cyc(); n++; end
        chk("drain_empty", 64'(sb.size()), 0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_valid"}, 64'(o_valid),  0);
        chk({tag, "_op"},    64'(o_op),     64'(OP_NOP));
        chk({tag, "_imm"},   64'(o_imm_se), 0);
        chk({tag, "_rdest"}, 64'(o_rdest),  0);
        chk({tag, "_pc"},    64'(o_pc),     0);
        chk({tag, "_rs1"},   64'(o_rs1_data), 0);
    endtask

    initial begin
        tv[0]  = mk(32'hFFF00093, OP_ADDI,  32'hFFFFFFFF, 5'd1, 0, 0, 1, 0);
        tv[1]  = mk(32'h4030D113, OP_SRAI,  32'h00000403, 5'd2, 0, 0, 1, 0);
        tv[2]  = mk(32'h00728333, OP_ADD,   32'h00000000, 5'd6, 0, 0, 1, 0);
        tv[3]  = mk(32'h0000007F, OP_NOP,   32'h00000000, 5'd0, 0, 0, 0, 1);
        tv[4]  = mk(32'h0020A423, OP_SW,    32'h00000008, 5'd8, 0, 0, 0, 0);
        tv[5]  = mk(32'hFE208EE3, OP_BEQ,   32'hFFFFFFFC, 5'd29, 1, 0, 0, 0);
        tv[6]  = mk(32'h001000EF, OP_JAL,   32'h00000800, 5'd1, 1, 0, 1, 0);
        tv[7]  = mk(32'h800001B7, OP_LUI,   32'h80000000, 5'd3, 0, 0, 1, 0);
        tv[8]  = mk(32'hFF80A203, OP_LW,    32'hFFFFFFF8, 5'd4, 0, 1, 1, 0);
        tv[9]  = mk(32'h00008067, OP_JALR,  32'h00000000, 5'd0, 1, 0, 0, 0);
        tv[10] = mk(32'h402091B3, OP_NOP,   32'h00000000, 5'd3, 0, 0, 0, 1);
        tv[11] = mk(32'h007372B3, OP_AND,   32'h00000000, 5'd5, 0, 0, 1, 0);
        tv[12] = mk(32'h00001397, OP_AUIPC, 32'h00001000, 5'd7, 0, 0, 1, 0);
        tv[13] = mk(32'h00720333, OP_ADD,   32'h00000000, 5'd6, 0, 0, 1, 0);

        rst = 1'b1; i_valid = 1'b0; i_instr = '0; i_pc = 32'h100; i_reg_rd_data = '0;
        i_load_pend = 1'b0; i_load_rdest = '0; i_flush = 1'b0; i_ready = 1'b0;
        rand_rs = 1'b1; cur_tv = tv[0];
        @(negedge clk);
        cyc(0);
        cyc(0);
        chk_reset_outs("reset");
        rst = 1'b0;

        // ADDI latency into an empty buffer, then SRAI with a fixed negative operand
        i_ready = 1'b1;
        push(0, 1);
        #1 chk("addi_latency_valid", 64'(o_valid), 1);
        chk("addi_pc", 64'(o_pc), 64'h100);
        i_instr = tv[1].instr;
        #1 chk("rd_addr_rs1", 64'(o_reg_rd_addr[0]), 1);
        chk("rd_addr_rs2", 64'(o_reg_rd_addr[1]), 3);
        rand_rs = 1'b0;
        i_reg_rd_data[0] = 32'h80000000;
        i_reg_rd_data[1] = 32'h0;
        push(1, 1);
        rand_rs = 1'b1;

        // full-rate stream through the remaining decode classes
        for (int k = 2; k <= 12; k++) push(k, 1);
        drain();

        // load-use stall on a pending execute-side load
        i_load_pend = 1'b1; i_load_rdest = 5'd5;
        cur_tv = tv[2]; i_instr = tv[2].instr; i_valid = 1'b1;
        cyc(0); cyc(0); cyc(0);
        i_load_pend = 1'b0;
        cyc(1);
        if (!last_acc) chk("loaduse_accept", 0, 1);
        i_valid = 1'b0; i_pc = i_pc + 32'd4;
        drain();

        // load still sitting in the buffer blocks a dependent instruction
        i_ready = 1'b0;
        push(8, 1);
        cur_tv = tv[13]; i_instr = tv[13].instr; i_valid = 1'b1;
        cyc(0); cyc(0);
        i_ready = 1'b1;
        cyc(0);
        cyc(1);
        if (!last_acc) chk("bufload_accept", 0, 1);
        i_valid = 1'b0; i_pc = i_pc + 32'd4;
        drain();

        // back-pressure: third push waits until a slot frees, no bypass when full
        i_ready = 1'b0;
        push(7, 1);
        push(11, 1);
        cur_tv = tv[12]; i_instr = tv[12].instr; i_valid = 1'b1;
        cyc(0); cyc(0);
        i_ready = 1'b1;
        cyc(0);
        cyc(1);
        if (!last_acc) chk("bp_third_accept", 0, 1);
        i_valid = 1'b0; i_pc = i_pc + 32'd4;
        drain();

        // flush drops buffered and incoming work
        i_ready = 1'b0;
        push(0, 1);
        push(6, 1);
        cur_tv = tv[4]; i_instr = tv[4].instr; i_valid = 1'b1; i_flush = 1'b1; i_ready = 1'b1;
        cyc(0);
        i_flush = 1'b0; i_valid = 1'b0;
        #1 chk("flush_valid", 64'(o_valid), 0);
        chk("flush_ready", 64'(o_ready), 1);
        push(12, 1);
        drain();

        // reset in the middle of buffered traffic
        i_ready = 1'b0;
        push(5, 1);
        push(8, 1);
        rst = 1'b1;
        cyc(0);
        rst = 1'b0;
        chk_reset_outs("midrst");
        i_ready = 1'b1;
        push(3, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
